// File: rtl/bp_fe_pkg.sv
// Front-end fetch buffer shared types: the stored entry layout and the
// exception kinds that can ride through the buffer in place of an instruction.
// Entry fields are sized for the widest supported PC/instruction; instances
// with narrower parameters zero-extend on write and slice on read.
package bp_fe_pkg;

  localparam int fb_max_vaddr_width_gp = 64;
  localparam int fb_max_instr_width_gp = 64;

  typedef enum logic [1:0] {
    e_fb_itlb_miss    = 2'd0,
    e_fb_page_fault   = 2'd1,
    e_fb_access_fault = 2'd2,
    e_fb_icache_miss  = 2'd3
  } fb_exception_code_e;

  typedef struct packed {
    logic [fb_max_vaddr_width_gp-1:0] pc;
    logic [fb_max_instr_width_gp-1:0] instr;
    logic                             exception_v;
    fb_exception_code_e               exception_code;
  } fb_entry_s;

endpackage

// File: rtl/bp_fe_fetch_buffer_ptr.sv
// Wrap-bit pointer for the fetch buffer. The pointer carries one bit more
// than the index so equal indices can be told apart as empty (wrap bits
// equal) or full (wrap bits differ). Depth must be a power of two so the
// index wraps modulo els_p without a compare.
module bp_fe_fetch_buffer_ptr #(
  parameter int els_p     = 8,
  parameter int max_add_p = 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [$clog2(max_add_p+1)-1:0]   add_i,
  output logic [$clog2(els_p):0]           ptr_o
);

  localparam int ptr_width_lp = $clog2(els_p) + 1;

  // advance by the number of entries moved this cycle; reset returns to slot 0
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_o <= '0;
    end else begin
      ptr_o <= ptr_o + ptr_width_lp'(add_i);
    end
  end

endmodule

// File: rtl/bp_fe_fetch_buffer.sv
// Fetch buffer between instruction fetch and decode. Each enqueue writes up
// to fetch_width_p consecutive instructions (PC steps of 4) or a single
// exception entry; entries leave one per cycle in FIFO order.
// Optional feature: define BP_FE_FETCH_BUFFER_BYPASS_EN to let lane 0 of an
// enqueue into an empty buffer appear on the outputs in the same cycle; when
// it is consumed right away it is never written to storage.
module bp_fe_fetch_buffer
  import bp_fe_pkg::*;
#(
  parameter int els_p         = 8,
  parameter int fetch_width_p = 2,
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   flush_i,
  input  logic                                   v_i,
  output logic                                   ready_and_o,
  input  logic [$clog2(fetch_width_p+1)-1:0]     count_i,
  input  logic [vaddr_width_p-1:0]               pc_i,
  input  logic [fetch_width_p*instr_width_p-1:0] instr_i,
  input  logic                                   exception_v_i,
  input  logic [1:0]                             exception_code_i,
  output logic                                   v_o,
  input  logic                                   ready_and_i,
  output logic [vaddr_width_p-1:0]               pc_o,
  output logic [instr_width_p-1:0]               instr_o,
  output logic                                   exception_v_o,
  output logic [1:0]                             exception_code_o,
  output logic [$clog2(els_p+1)-1:0]             occupancy_o
);

  localparam int lg_els_lp      = $clog2(els_p);
  localparam int ptr_width_lp   = lg_els_lp + 1;
  localparam int count_width_lp = $clog2(fetch_width_p + 1);
  localparam int occ_width_lp   = $clog2(els_p + 1);

  logic [ptr_width_lp-1:0]   rptr;
  logic [ptr_width_lp-1:0]   wptr;
  logic [ptr_width_lp-1:0]   occupancy;
  logic                      empty;
  logic                      ptr_reset;
  logic                      enq_fire;
  logic                      deq_fire;
  logic                      bypass_active;
  logic                      bypass_deq;
  logic [count_width_lp-1:0] enq_count;
  logic [count_width_lp-1:0] wr_add;
  logic                      rd_add;
  logic                      unused_hi_bits;

  fb_entry_s lane_entry [fetch_width_p];
  fb_entry_s mem        [els_p];
  fb_entry_s rd_entry;

  // Occupancy is the wrap-aware pointer distance; indices equal with wrap
  // bits differing yields els_p (full), fully equal pointers yield 0 (empty).
  assign occupancy   = wptr - rptr;
  assign empty       = (wptr == rptr);
  assign ready_and_o = (ptr_width_lp'(els_p) - occupancy) >= ptr_width_lp'(fetch_width_p);
  assign occupancy_o = occ_width_lp'(occupancy);

  assign enq_fire  = v_i & ready_and_o & ~flush_i;
  assign ptr_reset = reset_i | flush_i;

`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
  assign bypass_active = empty & enq_fire;
`else
  assign bypass_active = 1'b0;
`endif

  assign v_o        = (~empty | bypass_active) & ~flush_i;
  assign deq_fire   = v_o & ready_and_i;
  assign bypass_deq = bypass_active & ready_and_i;

  // number of entries an accepted enqueue produces; an exception is one entry
  always_comb begin
    enq_count = count_i;
    if (exception_v_i) begin
      enq_count = count_width_lp'(1);
    end else if (count_i > count_width_lp'(fetch_width_p)) begin
      enq_count = count_width_lp'(fetch_width_p);
    end
  end

  assign wr_add = enq_fire ? (enq_count - count_width_lp'(bypass_deq)) : '0;
  assign rd_add = deq_fire & ~bypass_deq;

  // build the per-lane entries; an exception replaces lane 0 with a PC-only entry
  always_comb begin
    for (int k = 0; k < fetch_width_p; k++) begin
      lane_entry[k]       = '0;
      lane_entry[k].pc    = fb_max_vaddr_width_gp'(vaddr_width_p'(pc_i + vaddr_width_p'(4 * k)));
      lane_entry[k].instr = fb_max_instr_width_gp'(instr_i[k*instr_width_p +: instr_width_p]);
    end
    if (exception_v_i) begin
      lane_entry[0].pc             = fb_max_vaddr_width_gp'(pc_i);
      lane_entry[0].instr          = '0;
      lane_entry[0].exception_v    = 1'b1;
      lane_entry[0].exception_code = fb_exception_code_e'(exception_code_i);
    end
  end

  // write accepted lanes into consecutive slots, skipping a lane consumed by bypass
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      for (int k = 0; k < fetch_width_p; k++) begin
        if ((k >= int'(bypass_deq)) && (k < int'(enq_count))) begin
          mem[lg_els_lp'(wptr[lg_els_lp-1:0] + lg_els_lp'(k) - lg_els_lp'(bypass_deq))] <= lane_entry[k];
        end
      end
    end
  end

  assign rd_entry = bypass_active ? lane_entry[0] : mem[rptr[lg_els_lp-1:0]];

  assign pc_o             = rd_entry.pc[vaddr_width_p-1:0];
  assign instr_o          = rd_entry.instr[instr_width_p-1:0];
  assign exception_v_o    = rd_entry.exception_v;
  assign exception_code_o = rd_entry.exception_code;

  assign unused_hi_bits = (^(rd_entry.pc >> vaddr_width_p)) ^ (^(rd_entry.instr >> instr_width_p));

  bp_fe_fetch_buffer_ptr #(
    .els_p    (els_p),
    .max_add_p(fetch_width_p)
  ) wr_ptr (
    .clk_i  (clk_i),
    .reset_i(ptr_reset),
    .add_i  (wr_add),
    .ptr_o  (wptr)
  );

  bp_fe_fetch_buffer_ptr #(
    .els_p    (els_p),
    .max_add_p(1)
  ) rd_ptr (
    .clk_i  (clk_i),
    .reset_i(ptr_reset),
    .add_i  (rd_add),
    .ptr_o  (rptr)
  );

  // an accepted fetch-line enqueue must carry between 1 and fetch_width_p lanes
  a_legal_count: assert property (@(posedge clk_i) disable iff (reset_i)
    (enq_fire && !exception_v_i) |-> ((count_i != '0) && (count_i <= count_width_lp'(fetch_width_p))));

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Directed self-checking bench for bp_fe_fetch_buffer (els_p=8, fetch_width_p=2).
// Expectations follow BP_FE_FETCH_BUFFER_BYPASS_EN when it is defined.
module tb_bp_fe_fetch_buffer;
  import bp_fe_pkg::*;

`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
  localparam bit bypass_lp = 1'b1;
`else
  localparam bit bypass_lp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        v_i;
  logic        ready_and_o;
  logic [1:0]  count_i;
  logic [38:0] pc_i;
  logic [63:0] instr_i;
  logic        exception_v_i;
  logic [1:0]  exception_code_i;
  logic        v_o;
  logic        ready_and_i;
  logic [38:0] pc_o;
  logic [31:0] instr_o;
  logic        exception_v_o;
  logic [1:0]  exception_code_o;
  logic [3:0]  occupancy_o;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [38:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  bp_fe_fetch_buffer #(
    .els_p(8), .fetch_width_p(2), .vaddr_width_p(39), .instr_width_p(32)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .v_i(v_i),
    .ready_and_o(ready_and_o), .count_i(count_i), .pc_i(pc_i), .instr_i(instr_i),
    .exception_v_i(exception_v_i), .exception_code_i(exception_code_i),
    .v_o(v_o), .ready_and_i(ready_and_i), .pc_o(pc_o), .instr_o(instr_o),
    .exception_v_o(exception_v_o), .exception_code_o(exception_code_o),
    .occupancy_o(occupancy_o)
  );

  // compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // drive every input, then let combinational outputs settle
  task automatic applyStimulus(input logic v, input logic [1:0] cnt, input logic [38:0] pc,
                               input logic [31:0] i0, input logic [31:0] i1, input logic exc,
                               input logic [1:0] code, input logic rdy, input logic flush);
    v_i              = v;
    count_i          = cnt;
    pc_i             = pc;
    instr_i          = {i1, i0};
    exception_v_i    = exc;
    exception_code_i = code;
    ready_and_i      = rdy;
    flush_i          = flush;
    #1;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 2'd0, 39'h0, 32'h0, 32'h0, 1'b0, 2'd0, rdy, 1'b0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        en;
    logic        rdy;
    logic        exp_v;
    logic [1:0]  cnt;
    logic [38:0] bpc;
    logic [31:0] i0;
    logic [31:0] i1;
    exp_t        head;
    int          sent;

    // reset, then idle
    reset_i = 1'b1;
    idle(1'b0);
    tick;
    tick;
    reset_i = 1'b0;
    tick;
    checkOutput("rst_v", 64'(v_o), 64'd0);
    checkOutput("rst_rdy", 64'(ready_and_o), 64'd1);
    checkOutput("rst_occ", 64'(occupancy_o), 64'd0);

    // two-lane then one-lane enqueue, drained in order
    applyStimulus(1'b1, 2'd2, 39'h1000, 32'hA0, 32'hA1, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("ord_rdy", 64'(ready_and_o), 64'd1);
    tick;
    applyStimulus(1'b1, 2'd1, 39'h1008, 32'hA2, 32'hFF, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("ord_occ2", 64'(occupancy_o), 64'd2);
    checkOutput("ord_v", 64'(v_o), 64'd1);
    tick;
    idle(1'b1);
    checkOutput("ord_occ3", 64'(occupancy_o), 64'd3);
    checkOutput("ord_pc0", 64'(pc_o), 64'h1000);
    checkOutput("ord_i0", 64'(instr_o), 64'hA0);
    tick;
    checkOutput("ord_pc1", 64'(pc_o), 64'h1004);
    checkOutput("ord_i1", 64'(instr_o), 64'hA1);
    tick;
    checkOutput("ord_pc2", 64'(pc_o), 64'h1008);
    checkOutput("ord_i2", 64'(instr_o), 64'hA2);
    checkOutput("ord_exc", 64'(exception_v_o), 64'd0);
    tick;
    idle(1'b0);
    checkOutput("ord_empty_v", 64'(v_o), 64'd0);
    checkOutput("ord_empty_occ", 64'(occupancy_o), 64'd0);

    // fill to 7 entries: ready drops, dequeue credit arrives one cycle later
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd2, 39'(39'h4000 + 8 * i), 32'h40, 32'h41, 1'b0, 2'd0, 1'b0, 1'b0);
      checkOutput("fill_rdy", 64'(ready_and_o), 64'd1);
      tick;
    end
    idle(1'b0);
    checkOutput("fill_occ6", 64'(occupancy_o), 64'd6);
    checkOutput("fill_rdy6", 64'(ready_and_o), 64'd1);
    applyStimulus(1'b1, 2'd1, 39'h4018, 32'h46, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick;
    idle(1'b0);
    checkOutput("fill_occ7", 64'(occupancy_o), 64'd7);
    checkOutput("fill_rdy7", 64'(ready_and_o), 64'd0);
    applyStimulus(1'b1, 2'd1, 39'h5000, 32'h50, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick;
    idle(1'b0);
    checkOutput("fill_reject", 64'(occupancy_o), 64'd7);
    idle(1'b1);
    checkOutput("fill_no_credit", 64'(ready_and_o), 64'd0);
    checkOutput("fill_head", 64'(pc_o), 64'h4000);
    tick;
    idle(1'b0);
    checkOutput("fill_credit", 64'(ready_and_o), 64'd1);
    checkOutput("fill_occ_after", 64'(occupancy_o), 64'd6);
    idle(1'b1);
    checkOutput("fill_head2", 64'(pc_o), 64'h4004);
    tick;
    idle(1'b0);
    checkOutput("fill_occ5", 64'(occupancy_o), 64'd5);

    // flush with 5 entries and a concurrent enqueue
    applyStimulus(1'b1, 2'd2, 39'h6000, 32'h60, 32'h61, 1'b0, 2'd0, 1'b1, 1'b1);
    checkOutput("flush_v_same", 64'(v_o), 64'd0);
    tick;
    idle(1'b0);
    checkOutput("flush_occ", 64'(occupancy_o), 64'd0);
    checkOutput("flush_v", 64'(v_o), 64'd0);
    checkOutput("flush_rdy", 64'(ready_and_o), 64'd1);

    // exception enqueue writes exactly one entry
    applyStimulus(1'b1, 2'd2, 39'h2000, 32'hDEAD, 32'hBEEF, 1'b1, e_fb_page_fault, 1'b0, 1'b0);
    tick;
    idle(1'b0);
    checkOutput("exc_occ", 64'(occupancy_o), 64'd1);
    checkOutput("exc_v", 64'(v_o), 64'd1);
    checkOutput("exc_flag", 64'(exception_v_o), 64'd1);
    checkOutput("exc_code", 64'(exception_code_o), 64'd1);
    checkOutput("exc_instr", 64'(instr_o), 64'd0);
    checkOutput("exc_pc", 64'(pc_o), 64'h2000);
    idle(1'b1);
    tick;
    idle(1'b0);
    checkOutput("exc_drain", 64'(occupancy_o), 64'd0);

    // reset mid-operation discards the concurrent enqueue and dequeue
    applyStimulus(1'b1, 2'd2, 39'h7000, 32'h70, 32'h71, 1'b0, 2'd0, 1'b0, 1'b0);
    tick;
    reset_i = 1'b1;
    applyStimulus(1'b1, 2'd2, 39'h7008, 32'h72, 32'h73, 1'b0, 2'd0, 1'b1, 1'b0);
    tick;
    reset_i = 1'b0;
    idle(1'b0);
    checkOutput("mrst_occ", 64'(occupancy_o), 64'd0);
    checkOutput("mrst_v", 64'(v_o), 64'd0);
    checkOutput("mrst_rdy", 64'(ready_and_o), 64'd1);

    // enqueue-to-valid latency on an empty buffer, single lane
    applyStimulus(1'b1, 2'd1, 39'h3000, 32'h30, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("lat_v_same", 64'(v_o), 64'(bypass_lp));
    if (bypass_lp) checkOutput("lat_pc_same", 64'(pc_o), 64'h3000);
    tick;
    idle(1'b1);
    checkOutput("lat_v_next", 64'(v_o), 64'(!bypass_lp));
    if (!bypass_lp) checkOutput("lat_pc_next", 64'(pc_o), 64'h3000);
    tick;
    idle(1'b0);
    checkOutput("lat_occ", 64'(occupancy_o), 64'd0);

    // two-lane enqueue on empty buffer with the consumer ready
    applyStimulus(1'b1, 2'd2, 39'h3100, 32'h31, 32'h32, 1'b0, 2'd0, 1'b1, 1'b0);
    if (bypass_lp) checkOutput("lat2_pc_same", 64'(pc_o), 64'h3100);
    tick;
    idle(1'b0);
    checkOutput("lat2_occ", 64'(occupancy_o), bypass_lp ? 64'd1 : 64'd2);
    checkOutput("lat2_pc", 64'(pc_o), bypass_lp ? 64'h3104 : 64'h3100);
    idle(1'b1);
    tick;
    if (!bypass_lp) tick;
    idle(1'b0);
    checkOutput("lat2_drain", 64'(occupancy_o), 64'd0);

    // 20 rounds across the wrap boundary against a queue scoreboard
    sent = 0;
    q.delete();
    for (int cyc = 0; cyc < 200 && !(sent == 20 && q.size() == 0); cyc++) begin
      en  = (sent < 20) && ((8 - q.size()) >= 2);
      cnt = 2'(1 + sent % 2);
      bpc = 39'(39'h8000 + 16 * sent);
      i0  = 32'hC0DE0000 + 32'(2 * sent);
      i1  = i0 + 32'd1;
      rdy = (cyc % 3 != 2);
      applyStimulus(en, cnt, bpc, i0, i1, 1'b0, 2'd0, rdy, 1'b0);
      checkOutput("wrap_rdy", 64'(ready_and_o), 64'((8 - q.size()) >= 2));
      exp_v = (q.size() > 0) || (bypass_lp && en);
      checkOutput("wrap_v", 64'(v_o), 64'(exp_v));
      if (exp_v) begin
        if (q.size() > 0) begin
          head = q[0];
        end else begin
          head.pc    = bpc;
          head.instr = i0;
        end
        checkOutput("wrap_pc", 64'(pc_o), 64'(head.pc));
        checkOutput("wrap_instr", 64'(instr_o), 64'(head.instr));
      end
      if (en) begin
        head.pc    = bpc;
        head.instr = i0;
        q.push_back(head);
        if (cnt == 2'd2) begin
          head.pc    = bpc + 39'd4;
          head.instr = i1;
          q.push_back(head);
        end
        sent++;
      end
      if (exp_v && rdy) void'(q.pop_front());
      tick;
    end
    idle(1'b0);
    checkOutput("wrap_sent", 64'(sent), 64'd20);
    checkOutput("wrap_drain", 64'(q.size()), 64'd0);
    checkOutput("wrap_occ", 64'(occupancy_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
